// File: rtl/rc4_prga_decrypt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rc4_prga_decrypt : RC4 keystream generator + decryptor, early abort on    |
// |                    the first illegal plaintext byte.   Revision: 1.0      |
// +--------------------------------------------------------------------------+
module rc4_prga_decrypt #(
  parameter int MSG_LEN  = 32,
  parameter int MSG_AW   = 5,
  parameter int CHECK_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        s_addr,
  output logic [7:0]        s_wdata,
  output logic              s_wren,
  input  logic [7:0]        s_rdata,
  output logic [MSG_AW-1:0] e_addr,
  input  logic [7:0]        e_rdata,
  output logic [MSG_AW-1:0] d_addr,
  output logic [7:0]        d_wdata,
  output logic              d_wren
);

  localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);
  localparam logic [MSG_AW-1:0] K_ONE  = MSG_AW'(1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_INC, ST_WI, ST_RI, ST_WJ, ST_RJ,
    ST_SWJ,  ST_RF,  ST_WF, ST_XOR, ST_CHK, ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [MSG_AW-1:0] k_q, k_d;
  logic [7:0]        s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
  logic              s_wren_q, s_wren_d;
  logic [MSG_AW-1:0] e_addr_q, e_addr_d, d_addr_q, d_addr_d;
  logic [7:0]        d_wdata_q, d_wdata_d;
  logic              d_wren_q, d_wren_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic              illegal;

  // Allowed plaintext alphabet: lowercase letters and space.
  always_comb begin
    illegal = 1'b0;
    if (CHECK_EN != 0) begin
      illegal = !(((d_wdata_q >= 8'h61) && (d_wdata_q <= 8'h7A)) || (d_wdata_q == 8'h20));
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    si_d      = si_q;
    sj_d      = sj_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_wren_d  = s_wren_q;
    e_addr_d  = e_addr_q;
    d_addr_d  = d_addr_q;
    d_wdata_d = d_wdata_q;
    d_wren_d  = d_wren_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          i_d     = 8'd0;
          j_d     = 8'd0;
          k_d     = '0;
          pass_d  = 1'b1;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_INC;
        end
      end
      ST_INC: begin
        i_d      = i_q + 8'd1;
        s_addr_d = i_q + 8'd1;
        e_addr_d = k_q;
        state_d  = ST_WI;
      end
      ST_WI: state_d = ST_RI;
      ST_RI: begin
        si_d     = s_rdata;
        j_d      = j_q + s_rdata;
        s_addr_d = j_q + s_rdata;
        state_d  = ST_WJ;
      end
      ST_WJ: state_d = ST_RJ;
      // Swap is two back-to-back writes; when i==j the second one wins with si.
      ST_RJ: begin
        sj_d      = s_rdata;
        s_addr_d  = i_q;
        s_wdata_d = s_rdata;
        s_wren_d  = 1'b1;
        state_d   = ST_SWJ;
      end
      ST_SWJ: begin
        s_addr_d  = j_q;
        s_wdata_d = si_q;
        s_wren_d  = 1'b1;
        state_d   = ST_RF;
      end
      ST_RF: begin
        s_wren_d = 1'b0;
        s_addr_d = si_q + sj_q;
        state_d  = ST_WF;
      end
      ST_WF: state_d = ST_XOR;
      ST_XOR: begin
        d_addr_d  = k_q;
        d_wdata_d = s_rdata ^ e_rdata;
        d_wren_d  = 1'b1;
        state_d   = ST_CHK;
      end
      ST_CHK: begin
        d_wren_d = 1'b0;
        if (illegal) begin
          pass_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (k_q == K_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + K_ONE;
          state_d = ST_INC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      i_q       <= 8'd0;
      j_q       <= 8'd0;
      k_q       <= '0;
      si_q      <= 8'd0;
      sj_q      <= 8'd0;
      s_addr_q  <= 8'd0;
      s_wdata_q <= 8'd0;
      s_wren_q  <= 1'b0;
      e_addr_q  <= '0;
      d_addr_q  <= '0;
      d_wdata_q <= 8'd0;
      d_wren_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      si_q      <= si_d;
      sj_q      <= sj_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_wren_q  <= s_wren_d;
      e_addr_q  <= e_addr_d;
      d_addr_q  <= d_addr_d;
      d_wdata_q <= d_wdata_d;
      d_wren_q  <= d_wren_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign s_wren  = s_wren_q;
  assign e_addr  = e_addr_q;
  assign d_addr  = d_addr_q;
  assign d_wdata = d_wdata_q;
  assign d_wren  = d_wren_q;

endmodule
`default_nettype wire
